// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multi-digit 7-segment controller.
//   - Active-high glyphs GLYPH_0..GLYPH_F, bit0=a .. bit6=g.
//   - SEG_BLANK, the all-off glyph.
//   - FSM state encoding IDLE / DECODE / COMMIT.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/seg7_multi_display_glyph_rom.sv
// seg7_glyph_rom: combinational nibble -> active-high 7-segment glyph.
//   i_nibble  in  4  value to decode
//   i_hex_en  in  1  1: 10..15 decode as A,b,C,d,E,F; 0: they are illegal
//   o_glyph   out 7  active-high segments, bit0=a .. bit6=g (blank if illegal)
//   o_illegal out 1  nibble > 9 while hex glyphs are disabled
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_en,
    output logic [6:0] o_glyph,
    output logic       o_illegal
);

    logic [6:0] w_raw;

    always_comb begin
        w_raw = SEG_BLANK;
        case (i_nibble)
            4'h0: w_raw = GLYPH_0;
            4'h1: w_raw = GLYPH_1;
            4'h2: w_raw = GLYPH_2;
            4'h3: w_raw = GLYPH_3;
            4'h4: w_raw = GLYPH_4;
            4'h5: w_raw = GLYPH_5;
            4'h6: w_raw = GLYPH_6;
            4'h7: w_raw = GLYPH_7;
            4'h8: w_raw = GLYPH_8;
            4'h9: w_raw = GLYPH_9;
            4'hA: w_raw = GLYPH_A;
            4'hB: w_raw = GLYPH_B;
            4'hC: w_raw = GLYPH_C;
            4'hD: w_raw = GLYPH_D;
            4'hE: w_raw = GLYPH_E;
            4'hF: w_raw = GLYPH_F;
            default: w_raw = SEG_BLANK;
        endcase
    end

    assign o_illegal = !i_hex_en && (i_nibble > 4'd9);
    assign o_glyph   = o_illegal ? SEG_BLANK : w_raw;

endmodule

// File: rtl/seg7_multi_display.sv
// seg7_multi_display: registered N-digit 7-segment controller.
// A packed nibble vector is accepted over valid/ready, decoded MSB-first one
// digit per cycle into a shadow register, then committed to the output
// registers in one edge so the display never shows a partial update.
//   clk, rst_n      clock, asynchronous active-low reset
//   load_valid/ready handshake; ready is high only in IDLE
//   load_value      nibble i = digit i (digit 0 rightmost)
//   blank_lz        leading-zero suppression, sampled at accept
//   dp_in           per-digit decimal points, sampled at accept
//   segs_out        digit i at [7*i+6:7*i], polarity per ACTIVE_LOW
//   dp_out          decimal points, polarity per ACTIVE_LOW
//   bad_digit       one-cycle pulse with a commit holding an illegal nibble
//   blink_en        whole-display blink (only with SEG7_BLINK_EN defined)
// Optional feature macro: SEG7_BLINK_EN (blink counter, phase and blink_en port).
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7*NUM_DIGITS-1:0] segs_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    bad_digit
`ifdef SEG7_BLINK_EN
    ,
    input  logic                    blink_en
`endif
);

    localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    // Unlit patterns in output polarity.
    localparam logic [7*NUM_DIGITS-1:0] SEGS_OFF = {(7*NUM_DIGITS){POL}};
    localparam logic [NUM_DIGITS-1:0]   DP_OFF   = {NUM_DIGITS{POL}};

    logic [1:0]                  r_state;
    logic [IW-1:0]               r_idx;
    logic [4*NUM_DIGITS-1:0]     r_value;
    logic                        r_blank_lz;
    logic [NUM_DIGITS-1:0]       r_dp;
    logic                        r_seen_nz;
    logic                        r_bad;
    logic [NUM_DIGITS-1:0][6:0]  r_shadow;
    logic [7*NUM_DIGITS-1:0]     r_segs;
    logic [NUM_DIGITS-1:0]       r_dp_out;
    logic                        r_bad_digit;

    logic [3:0] w_nib;
    logic [6:0] w_glyph;
    logic       w_illegal;
    logic       w_lz_blank;

    // Single ROM shared by all digits via the idx mux.
    assign w_nib = r_value[{r_idx, 2'b00} +: 4];

    seg7_glyph_rom u_rom (
        .i_nibble  (w_nib),
        .i_hex_en  (HEX_MODE != 0),
        .o_glyph   (w_glyph),
        .o_illegal (w_illegal)
    );

    // Leading zero: nothing nonzero seen yet from the MSB side; digit 0 always shows.
    assign w_lz_blank = r_blank_lz && !r_seen_nz && (w_nib == 4'd0) && (r_idx != '0);

    assign load_ready = (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_value     <= '0;
            r_blank_lz  <= 1'b0;
            r_dp        <= '0;
            r_seen_nz   <= 1'b0;
            r_bad       <= 1'b0;
            r_shadow    <= '{default: SEG_BLANK};
            r_segs      <= SEGS_OFF;
            r_dp_out    <= DP_OFF;
            r_bad_digit <= 1'b0;
        end else begin
            r_bad_digit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_value    <= load_value;
                        r_blank_lz <= blank_lz;
                        r_dp       <= dp_in;
                        r_idx      <= IW'(NUM_DIGITS - 1);
                        r_seen_nz  <= 1'b0;
                        r_bad      <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_shadow[r_idx] <= w_lz_blank ? SEG_BLANK : w_glyph;
                    // Illegal nibbles are nonzero, so they also end zero suppression.
                    if (w_nib != 4'd0) r_seen_nz <= 1'b1;
                    if (w_illegal)     r_bad     <= 1'b1;
                    if (r_idx == '0) r_state <= ST_COMMIT;
                    else             r_idx   <= r_idx - IW'(1);
                end
                ST_COMMIT: begin
                    r_segs      <= r_shadow ^ SEGS_OFF;
                    r_dp_out    <= r_dp ^ DP_OFF;
                    r_bad_digit <= r_bad;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bad_digit = r_bad_digit;

`ifdef SEG7_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_mask;

    // Free-running half-period counter; dropping blink_en restarts it visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_mask  <= 1'b0;
        end else if (!blink_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_mask  <= 1'b0;
        end else begin
            if (r_cnt == CW'(BLINK_DIV - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_mask <= r_phase;
        end
    end

    assign segs_out = r_mask ? SEGS_OFF : r_segs;
    assign dp_out   = r_mask ? DP_OFF   : r_dp_out;
`else
    assign segs_out = r_segs;
    assign dp_out   = r_dp_out;
`endif

endmodule

// File: tb/tb_seg7_multi_display.sv
// Bench for seg7_multi_display: two instances share stimulus,
// u0 = HEX_MODE 0 / ACTIVE_LOW 1, u1 = HEX_MODE 1 / ACTIVE_LOW 0.
module tb_seg7_multi_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lv = 1'b0;
    logic [15:0] lval = '0;
    logic        lblz = 1'b0;
    logic [3:0]  ldp = '0;
    logic        rdy0, rdy1, bad0, bad1;
    logic [27:0] segs0, segs1;
    logic [3:0]  dpo0, dpo1;
`ifdef SEG7_BLINK_EN
    logic        blink_en = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_multi_display #(.NUM_DIGITS(4), .HEX_MODE(0), .ACTIVE_LOW(1), .BLINK_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(rdy0),
        .load_value(lval), .blank_lz(lblz), .dp_in(ldp),
        .segs_out(segs0), .dp_out(dpo0), .bad_digit(bad0)
`ifdef SEG7_BLINK_EN
        , .blink_en(blink_en)
`endif
    );

    seg7_multi_display #(.NUM_DIGITS(4), .HEX_MODE(1), .ACTIVE_LOW(0), .BLINK_DIV(4)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(rdy1),
        .load_value(lval), .blank_lz(lblz), .dp_in(ldp),
        .segs_out(segs1), .dp_out(dpo1), .bad_digit(bad1)
`ifdef SEG7_BLINK_EN
        , .blink_en(blink_en)
`endif
    );

    // Active-high glyphs (gfedcba) for 0..F.
    localparam logic [6:0] TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // Reference: digit i is blank if suppression is on, i>0 and the value
    // above and including digit i is zero; illegal nibbles are blank.
    function automatic logic [27:0] model_segs(input logic [15:0] v, input logic blz,
                                               input bit hex, input bit al);
        logic [27:0] r;
        logic [6:0]  g;
        int          nib;
        int          upper;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            upper = int'(v) >> (4 * i);
            nib   = upper % 16;
            g     = TBL[nib];
            if (!hex && nib > 9) g = 7'h00;
            if (blz && i > 0 && upper == 0) g = 7'h00;
            r[7*i +: 7] = al ? ~g : g;
        end
        return r;
    endfunction

    function automatic logic model_bad(input logic [15:0] v, input bit hex);
        for (int i = 0; i < 4; i++)
            if (!hex && ((int'(v) >> (4 * i)) % 16) > 9) return 1'b1;
        return 1'b0;
    endfunction

    // Currently displayed (expected) patterns.
    logic [27:0] exp_s0 = 28'hFFFFFFF;
    logic [27:0] exp_s1 = 28'h0;
    logic [3:0]  exp_d0 = 4'hF;
    logic [3:0]  exp_d1 = 4'h0;

    // Observations captured by do_load; each test compares them itself.
    logic [4:0]  ob_rdy;
    logic [27:0] ob_hold0 [5];
    logic [27:0] ob_hold1 [5];
    logic        ob_badb, ob_rdy_done, ob_bad0, ob_bad1, ob_bad_after, ob_timeout;
    logic [27:0] ob_s0, ob_s1;
    logic [3:0]  ob_d0, ob_d1;

    // Entered and left #1 after a rising edge.
    task automatic do_load(input logic [15:0] v, input logic blz, input logic [3:0] dp);
        int guard = 0;
        while (!rdy0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        ob_timeout = !rdy0;
        lv = 1'b1; lval = v; lblz = blz; ldp = dp;
        @(posedge clk); #1;
        lv = 1'b0;
        ob_badb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            ob_rdy[k]   = rdy0;
            ob_hold0[k] = segs0;
            ob_hold1[k] = segs1;
            ob_badb     = ob_badb | bad0 | bad1;
        end
        @(posedge clk); #1;
        ob_rdy_done = rdy0; ob_s0 = segs0; ob_s1 = segs1;
        ob_d0 = dpo0; ob_d1 = dpo1; ob_bad0 = bad0; ob_bad1 = bad1;
        @(posedge clk); #1;
        ob_bad_after = bad0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (segs0 !== 28'hFFFFFFF) begin n_err++; $display("FAIL reset_segs0 got %h want %h", segs0, 28'hFFFFFFF); end
        n_cmp++; if (segs1 !== 28'h0) begin n_err++; $display("FAIL reset_segs1 got %h want 0", segs1); end
        n_cmp++; if (dpo0 !== 4'hF) begin n_err++; $display("FAIL reset_dp0 got %h want F", dpo0); end
        n_cmp++; if (bad0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_flags got bad=%b rdy=%b want 0 1", bad0, rdy0); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [27:0] w0, w1;
        w0 = model_segs(16'h1234, 1'b0, 1'b0, 1'b1);
        w1 = model_segs(16'h1234, 1'b0, 1'b1, 1'b0);
        do_load(16'h1234, 1'b0, 4'b0101);
        n_cmp++; if (ob_timeout) begin n_err++; $display("FAIL basic_ready_wait got timeout want ready"); end
        n_cmp++; if (ob_rdy !== 5'b00000) begin n_err++; $display("FAIL basic_busy_ready got %b want 00000", ob_rdy); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (ob_hold0[k] !== exp_s0 || ob_hold1[k] !== exp_s1) begin
                n_err++; $display("FAIL basic_hold[%0d] got %h/%h want %h/%h", k, ob_hold0[k], ob_hold1[k], exp_s0, exp_s1);
            end
        end
        n_cmp++; if (ob_s0 !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin n_err++; $display("FAIL basic_literal got %b", ob_s0); end
        n_cmp++; if (ob_s0 !== w0 || ob_s1 !== w1) begin n_err++; $display("FAIL basic_model got %h/%h want %h/%h", ob_s0, ob_s1, w0, w1); end
        n_cmp++; if (ob_d0 !== 4'b1010 || ob_d1 !== 4'b0101) begin n_err++; $display("FAIL basic_dp got %b/%b want 1010/0101", ob_d0, ob_d1); end
        n_cmp++; if (ob_rdy_done !== 1'b1 || ob_bad0 !== 1'b0) begin n_err++; $display("FAIL basic_done got rdy=%b bad=%b want 1 0", ob_rdy_done, ob_bad0); end
        exp_s0 = w0; exp_s1 = w1; exp_d0 = 4'b1010; exp_d1 = 4'b0101;
    endtask

    task automatic test_lz();
        logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'h0105};
        logic [27:0] lits [3] = '{{7'h7F, 7'h7F, 7'h7F, 7'b1111000},
                                  {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                                  {7'h7F, 7'b1111001, 7'b1000000, 7'b0010010}};
        for (int t = 0; t < 3; t++) begin
            do_load(vals[t], 1'b1, 4'b0000);
            n_cmp++; if (ob_s0 !== lits[t]) begin n_err++; $display("FAIL lz_literal %h got %b want %b", vals[t], ob_s0, lits[t]); end
            n_cmp++; if (ob_s1 !== model_segs(vals[t], 1'b1, 1'b1, 1'b0)) begin n_err++; $display("FAIL lz_hex_inst %h got %h", vals[t], ob_s1); end
            n_cmp++; if (ob_d0 !== 4'hF || ob_d1 !== 4'h0) begin n_err++; $display("FAIL lz_dp got %b/%b want 1111/0000", ob_d0, ob_d1); end
            exp_s0 = ob_s0; exp_s1 = model_segs(vals[t], 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_illegal();
        do_load(16'h12A4, 1'b0, 4'b0000);
        n_cmp++; if (ob_s0[13:7] !== 7'h7F) begin n_err++; $display("FAIL illegal_blank got %b want 1111111", ob_s0[13:7]); end
        n_cmp++; if (ob_s0 !== model_segs(16'h12A4, 1'b0, 1'b0, 1'b1)) begin n_err++; $display("FAIL illegal_model got %h", ob_s0); end
        n_cmp++; if (ob_bad0 !== 1'b1) begin n_err++; $display("FAIL illegal_bad_commit got %b want 1", ob_bad0); end
        n_cmp++; if (ob_badb !== 1'b0 || ob_bad_after !== 1'b0) begin n_err++; $display("FAIL illegal_bad_pulse got busy=%b after=%b want 0 0", ob_badb, ob_bad_after); end
        n_cmp++; if (ob_s1[13:7] !== 7'b1110111 || ob_bad1 !== 1'b0) begin n_err++; $display("FAIL hex_A got %b bad=%b want 1110111 0", ob_s1[13:7], ob_bad1); end
        exp_s0 = ob_s0; exp_s1 = model_segs(16'h12A4, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'h5678; b = 16'h9ABC;
        lv = 1'b1; lval = a; lblz = 1'b0; ldp = 4'b0011;
        @(posedge clk); #1;
        lval = b; ldp = 4'b1100;           // held valid through busy
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
        n_cmp++; if (segs0 !== model_segs(a, 1'b0, 1'b0, 1'b1) || rdy0 !== 1'b1) begin n_err++; $display("FAIL b2b_first got %h rdy=%b", segs0, rdy0); end
        @(posedge clk); #1;
        n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL b2b_accept got rdy=%b want 0", rdy0); end
        lv = 1'b0;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
        n_cmp++; if (segs0 !== model_segs(b, 1'b0, 1'b0, 1'b1) || bad0 !== 1'b1) begin n_err++; $display("FAIL b2b_second got %h bad=%b", segs0, bad0); end
        n_cmp++; if (segs1 !== model_segs(b, 1'b0, 1'b1, 1'b0) || dpo1 !== 4'b1100) begin n_err++; $display("FAIL b2b_second_hex got %h dp=%b", segs1, dpo1); end
        exp_s0 = segs0; exp_s1 = model_segs(b, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic        z;
        logic [3:0]  d;
        for (int t = 0; t < 24; t++) begin
            v = 16'($urandom) >> (4 * $urandom_range(0, 3));
            z = 1'($urandom);
            d = 4'($urandom);
            do_load(v, z, d);
            n_cmp++;
            if (ob_s0 !== model_segs(v, z, 1'b0, 1'b1) || ob_s1 !== model_segs(v, z, 1'b1, 1'b0)) begin
                n_err++; $display("FAIL rand_segs v=%h lz=%b got %h/%h want %h/%h", v, z, ob_s0, ob_s1,
                                  model_segs(v, z, 1'b0, 1'b1), model_segs(v, z, 1'b1, 1'b0));
            end
            n_cmp++;
            if (ob_d0 !== ~d || ob_d1 !== d || ob_bad0 !== model_bad(v, 1'b0) || ob_bad1 !== 1'b0) begin
                n_err++; $display("FAIL rand_flags v=%h got dp=%b/%b bad=%b/%b", v, ob_d0, ob_d1, ob_bad0, ob_bad1);
            end
            exp_s0 = model_segs(v, z, 1'b0, 1'b1); exp_s1 = model_segs(v, z, 1'b1, 1'b0);
        end
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        logic hide;
        do_load(16'h4321, 1'b0, 4'b0000);
        exp_s0 = model_segs(16'h4321, 1'b0, 1'b0, 1'b1);
        blink_en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            hide = (((k - 1) / 4) % 2) == 1;
            n_cmp++;
            if (segs0 !== (hide ? 28'hFFFFFFF : exp_s0) || rdy0 !== 1'b1) begin
                n_err++; $display("FAIL blink_cycle%0d got %h rdy=%b want %h", k, segs0, rdy0, hide ? 28'hFFFFFFF : exp_s0);
            end
        end
        blink_en = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (segs0 !== exp_s0) begin n_err++; $display("FAIL blink_drop got %h want %h", segs0, exp_s0); end
    endtask
`endif

    task automatic test_reset_mid();
        lv = 1'b1; lval = 16'h8888; lblz = 1'b0; ldp = 4'hF;
        @(posedge clk); #1;
        lv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (segs0 !== 28'hFFFFFFF || segs1 !== 28'h0) begin n_err++; $display("FAIL rstmid_blank got %h/%h", segs0, segs1); end
        n_cmp++; if (dpo0 !== 4'hF || rdy0 !== 1'b1) begin n_err++; $display("FAIL rstmid_flags got dp=%b rdy=%b", dpo0, rdy0); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin @(posedge clk); #1; end
        n_cmp++; if (segs0 !== 28'hFFFFFFF || bad0 !== 1'b0) begin n_err++; $display("FAIL rstmid_discard got %h bad=%b", segs0, bad0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_illegal();
        test_back_to_back();
        test_random();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
